mod100_count_controller: RTL and testbench
==========================================

# mod100_count_controller

Sequencing controller for a two-digit BCD 00–99 up-count datapath. It owns the tens/ones digit registers and decides when they advance, hold, clear, preload or reload. Requesters issue start/stop/clear/load commands; the block advances only on an external `tick` strobe and reports target match and wrap events. It sits between system control logic and any display or timing consumer of the BCD count.

## Interface
- `RELOAD_VAL`, default 8'h00: BCD value written to `count` on an auto-reload after target match.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  count-enable strobe, sampled each `clk` edge.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting.
- `clear`  in  1  force count to 00 and return to idle.
- `load`  in  1  preload request.
- `load_val`  in  8  BCD preload value: [7:4] tens, [3:0] ones.
- `target`  in  8  BCD terminal value that is compared against the next count.
- `auto_reload`  in  1  1 = reload `RELOAD_VAL` on match and keep running; 0 = stop in DONE.
- `count`  out  8  BCD count: [7:4] tens, [3:0] ones.
- `running`  out  1  high while the state is RUN.
- `done`  out  1  one-cycle pulse on target match.
- `wrap`  out  1  one-cycle pulse on the 99→00 rollover.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSE, DONE. `rst` forces IDLE, `count`=00, and `running`, `done`, `wrap`, `load_err` all 0.
- Command priority within one cycle: `rst` > `clear` > `load` > `stop` > `start` > `tick`. Only the highest-priority active command takes effect.
- `clear`: in any state, sets `count`=00 and goes to IDLE.
- `load` with both digits ≤9: sets `count`=`load_val` and goes to IDLE.
- `load` with either digit >9: `count` and state are unchanged, and `load_err` pulses.
- `stop` in RUN goes to PAUSE. In any other state it has no effect.
- `start` transitions:
  - IDLE or PAUSE → RUN, with `count` held.
  - DONE → RUN, with `count` set to 00.
- `tick` in RUN: next = `count`+1 in BCD. Ones 9→0 carries into tens; 99→00 wraps and pulses `wrap`.
- Target match (next == `target`), when `auto_reload`=0: `count`=next, state goes to DONE, `done` pulses.
- Target match, when `auto_reload`=1: `count`=`RELOAD_VAL`, state stays RUN, `done` pulses.
- `target`=00 matches on the wrap cycle, so `wrap` and `done` pulse together.
- A `target` with a digit >9 never matches.
- `tick` outside RUN is ignored.
- `tick` in the same cycle as `stop`, `clear` or `load`: no increment occurs.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Command or tick sampled at edge N: `count`, `running`, `done`, `wrap` and `load_err` reflect it from edge N through edge N+1. Latency is one cycle.
- Each pulse lasts exactly one cycle per qualifying event. Back-to-back ticks produce back-to-back pulses.
- `running` is 1 in the cycle after `start` is accepted. It is 0 in the cycle after `stop`, `clear`, `load` or a non-reload match.
- Maximum count rate is one increment per `clk` when `tick` is held high.

## Structure
- Shared package holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - `BCD_MAX_DIGIT`=4'd9;
  - 8-bit BCD count type;
  - a BCD-valid check function.
- One sub-module, `bcd_decade_counter`: one 4-bit digit with enable, synchronous clear, load, and carry-out on 9→0. It is instantiated twice, with the ones carry gating the tens enable.
- Controller FSM, target comparator and pulse registers live in the top module.

## Test plan
- Reset, start, then 12 ticks → `count`=8'h12, `running`=1, no pulses.
- Load 8'h97, start, then 3 ticks with `target`=8'h50 → `count` goes 98, 99, 00; `wrap` pulses on the third tick only.
- `target`=8'h05, `auto_reload`=0, from 00 with 5 ticks → `count`=05, `done` pulses once, state DONE, further ticks ignored; `start` → `count`=00, RUN.
- `auto_reload`=1, `RELOAD_VAL`=8'h00, `target`=8'h03, 7 ticks → sequence 01, 02, 00, 01, 02, 00, 01; `done` pulses on ticks 3 and 6.
- `load_val`=8'h3A → `load_err` pulses, `count` unchanged. Same-cycle `stop`+`tick` in RUN → PAUSE with `count` unchanged.
- `clear`+`load`+`start` asserted together mid-RUN at 8'h42 → `count`=00, IDLE, `running`=0; then `rst` mid-count → every output is 0 on the next cycle.

Source files
------------

// File: rtl/mod100_count_controller_pkg.sv
// Shared types and helpers for the two-digit BCD count controller.
package mod100_count_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [7:0] bcd8_t;

  // True when both nibbles are legal decimal digits.
  function automatic logic bcd_valid(input bcd8_t v);
    return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
  endfunction

  // Two-digit BCD increment with 99 -> 00 rollover.
  function automatic bcd8_t bcd_inc(input bcd8_t v);
    bcd8_t r;
    r = v;
    if (v[3:0] == BCD_MAX_DIGIT) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == BCD_MAX_DIGIT) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod100_count_controller_decade.sv
// One BCD digit: sync clear, load, enable, carry-out on the 9 -> 0 step.
module bcd_decade_counter
  import mod100_count_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       carry
);

  // Carry is combinational so the next digit can step in the same cycle.
  assign carry = en && (q == BCD_MAX_DIGIT);

  // Digit register; clear beats load beats increment.
  always_ff @(posedge clk) begin
    if (rst)       q <= 4'd0;
    else if (clr)  q <= 4'd0;
    else if (ld)   q <= ld_val;
    else if (en)   q <= carry ? 4'd0 : q + 4'd1;
  end

endmodule

// File: rtl/mod100_count_controller.sv
// Command sequencer for a 00-99 BCD up-counter with target match and reload.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | stopped after reset, clear or load; waits for start
//   ST_RUN   | advances one count per tick
//   ST_PAUSE | stopped by stop; start resumes with count held
//   ST_DONE  | target reached without auto-reload; start restarts at 00
module mod100_count_controller
  import mod100_count_controller_pkg::*;
#(
  parameter logic [7:0] RELOAD_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] target,
  input  logic       auto_reload,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic       load_err
);

  state_t state, state_n;
  logic   dig_en, dig_clr, dig_ld;
  bcd8_t  dig_ld_val;
  logic   ones_carry, tens_carry;
  logic   done_n, err_n;
  logic   tgt_hit;

  // An invalid target can never equal a legal BCD count, but reject it explicitly.
  assign tgt_hit = bcd_valid(target) && (bcd_inc(count) == target);

  bcd_decade_counter u_ones (
    .clk    (clk),
    .rst    (rst),
    .en     (dig_en),
    .clr    (dig_clr),
    .ld     (dig_ld),
    .ld_val (dig_ld_val[3:0]),
    .q      (count[3:0]),
    .carry  (ones_carry)
  );

  bcd_decade_counter u_tens (
    .clk    (clk),
    .rst    (rst),
    .en     (ones_carry),
    .clr    (dig_clr),
    .ld     (dig_ld),
    .ld_val (dig_ld_val[7:4]),
    .q      (count[7:4]),
    .carry  (tens_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Prioritised command decode: clear > load > stop > start > tick.
  // On a reload match the increment enable stays high so the tens carry still
  // flags the 99 -> 00 step; the digit load overrides the increment itself.
  always_comb begin
    state_n    = state;
    dig_en     = 1'b0;
    dig_clr    = 1'b0;
    dig_ld     = 1'b0;
    dig_ld_val = load_val;
    done_n     = 1'b0;
    err_n      = 1'b0;
    if (clear) begin
      dig_clr = 1'b1;
      state_n = ST_IDLE;
    end else if (load) begin
      if (bcd_valid(load_val)) begin
        dig_ld  = 1'b1;
        state_n = ST_IDLE;
      end else begin
        err_n = 1'b1;
      end
    end else if (stop) begin
      if (state == ST_RUN) state_n = ST_PAUSE;
    end else if (start) begin
      if (state == ST_DONE) dig_clr = 1'b1;
      state_n = ST_RUN;
    end else if (tick && (state == ST_RUN)) begin
      dig_en = 1'b1;
      if (tgt_hit) begin
        done_n = 1'b1;
        if (auto_reload) begin
          dig_ld     = 1'b1;
          dig_ld_val = RELOAD_VAL;
        end else begin
          state_n = ST_DONE;
        end
      end
    end
  end

  // Event pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= done_n;
      wrap     <= tens_carry;
      load_err <= err_n;
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_mod100_count_controller.sv
// Directed bench with a decimal-arithmetic reference model checked every cycle.
module tb_mod100_count_controller;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, clear, load, auto_reload;
  logic [7:0] load_val, target;
  logic [7:0] count;
  logic       running, done, wrap, load_err;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  localparam logic [7:0] TB_RELOAD = 8'h00;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  int m_val, m_st;
  bit m_done, m_wrap, m_err;

  mod100_count_controller #(.RELOAD_VAL(TB_RELOAD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_val(load_val), .target(target),
    .auto_reload(auto_reload), .count(count), .running(running),
    .done(done), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic bit ok_bcd(input logic [7:0] v);
    return (v[7:4] < 4'd10) && (v[3:0] < 4'd10);
  endfunction

  function automatic int to_dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value plus state, updated from sampled inputs.
  always @(posedge clk) begin
    int nxt;
    m_done = 0; m_wrap = 0; m_err = 0;
    if (rst) begin
      m_val = 0; m_st = M_IDLE;
    end else if (clear) begin
      m_val = 0; m_st = M_IDLE;
    end else if (load) begin
      if (ok_bcd(load_val)) begin
        m_val = to_dec(load_val); m_st = M_IDLE;
      end else m_err = 1;
    end else if (stop) begin
      if (m_st == M_RUN) m_st = M_PAUSE;
    end else if (start) begin
      if (m_st == M_DONE) m_val = 0;
      m_st = M_RUN;
    end else if (tick && m_st == M_RUN) begin
      nxt = (m_val + 1) % 100;
      m_wrap = (m_val == 99);
      if (ok_bcd(target) && nxt == to_dec(target)) begin
        m_done = 1;
        if (auto_reload) m_val = to_dec(TB_RELOAD);
        else begin m_val = nxt; m_st = M_DONE; end
      end else m_val = nxt;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_count", count, to_bcd(m_val));
      chk("cyc_running", {7'd0, running}, {7'd0, m_st == M_RUN});
      chk("cyc_done", {7'd0, done}, {7'd0, m_done});
      chk("cyc_wrap", {7'd0, wrap}, {7'd0, m_wrap});
      chk("cyc_load_err", {7'd0, load_err}, {7'd0, m_err});
    end
  end

  task automatic drive(input logic t, input logic st, input logic sp,
                       input logic cl, input logic ld, input logic [7:0] lv);
    tick = t; start = st; stop = sp; clear = cl; load = ld; load_val = lv;
    @(negedge clk);
  endtask

  task automatic do_tick();  drive(1, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_start(); drive(0, 1, 0, 0, 0, 8'h00); endtask
  task automatic do_idle();  drive(0, 0, 0, 0, 0, 8'h00); endtask

  logic [7:0] seq_exp [7] = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h01};

  initial begin
    rst = 1; tick = 0; start = 0; stop = 0; clear = 0; load = 0;
    load_val = 8'h00; target = 8'h50; auto_reload = 0;
    @(posedge clk); @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 8'h00);
    chk("rst_running", {7'd0, running}, 8'h00);
    chk("rst_pulses", {5'd0, done, wrap, load_err}, 8'h00);
    rst = 0;

    // 12 ticks from 00
    do_start();
    repeat (12) do_tick();
    chk("t1_count", count, 8'h12);
    chk("t1_model", to_bcd(m_val), 8'h12);
    chk("t1_running", {7'd0, running}, 8'h01);
    chk("t1_pulses", {6'd0, done, wrap}, 8'h00);

    // rollover 97 -> 98 -> 99 -> 00
    drive(0, 0, 0, 0, 1, 8'h97);
    do_start();
    do_tick(); chk("t2_98", count, 8'h98);
    do_tick(); chk("t2_99", count, 8'h99); chk("t2_nowrap", {7'd0, wrap}, 8'h00);
    do_tick(); chk("t2_00", count, 8'h00); chk("t2_wrap", {7'd0, wrap}, 8'h01);
    chk("t2_model_wrap", {7'd0, m_wrap}, 8'h01);
    do_idle(); chk("t2_wrap_end", {7'd0, wrap}, 8'h00);

    // target 00 matches on the wrap cycle
    target = 8'h00;
    drive(0, 0, 0, 0, 1, 8'h98);
    do_start();
    do_tick(); do_tick();
    chk("t2b_count", count, 8'h00);
    chk("t2b_wrap_done", {6'd0, wrap, done}, 8'h03);
    chk("t2b_running", {7'd0, running}, 8'h00);

    // non-reload match at 05
    target = 8'h05; auto_reload = 0;
    drive(0, 0, 0, 1, 0, 8'h00);
    do_start();
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      chk("t3_count", count, 8'(i));
      chk("t3_done", {7'd0, done}, {7'd0, i == 5});
    end
    chk("t3_running", {7'd0, running}, 8'h00);
    do_tick(); do_tick();
    chk("t3_hold", count, 8'h05);
    chk("t3_done_end", {7'd0, done}, 8'h00);
    do_start();
    chk("t3_restart", count, 8'h00);
    chk("t3_restart_run", {7'd0, running}, 8'h01);

    // auto-reload at 03
    auto_reload = 1; target = 8'h03;
    for (int i = 0; i < 7; i++) begin
      do_tick();
      chk("t4_count", count, seq_exp[i]);
      chk("t4_done", {7'd0, done}, {7'd0, i == 2 || i == 5});
      chk("t4_running", {7'd0, running}, 8'h01);
    end

    // rejected load, then stop with tick
    auto_reload = 0; target = 8'h50;
    drive(0, 0, 0, 0, 1, 8'h3A);
    chk("t5_err", {7'd0, load_err}, 8'h01);
    chk("t5_count", count, 8'h01);
    chk("t5_running", {7'd0, running}, 8'h01);
    drive(1, 0, 1, 0, 0, 8'h00);
    chk("t5_stop_count", count, 8'h01);
    chk("t5_stop_run", {7'd0, running}, 8'h00);
    do_tick();
    chk("t5_pause_tick", count, 8'h01);

    // clear beats load and start mid-run
    drive(0, 0, 0, 0, 1, 8'h42);
    do_start();
    chk("t6_at42", count, 8'h42);
    drive(0, 1, 0, 1, 1, 8'h77);
    chk("t6_clear", count, 8'h00);
    chk("t6_clear_run", {7'd0, running}, 8'h00);
    do_start();
    do_tick(); do_tick();
    chk("t6_count", count, 8'h02);
    rst = 1;
    do_tick();
    chk("t6_rst_count", count, 8'h00);
    chk("t6_rst_outs", {4'd0, running, done, wrap, load_err}, 8'h00);
    rst = 0;
    do_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
